// File: rtl/enigma_pkg.sv
// Shared widths, rotor FSM state encoding and small modular-arithmetic helpers.
package enigma_pkg;

    localparam int unsigned CODE_W      = 6;
    localparam int unsigned TABLE_DEPTH = 64;
    localparam int unsigned ADDR_W      = $clog2(TABLE_DEPTH);
    localparam int unsigned ST_W        = 2;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Rotor FSM states, kept as plain constants so legacy blocks can compare against them.
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd2;

    // Wrap-around subtraction of the rotor offset; no saturation.
    function automatic code_t code_sub(input code_t a, input code_t b);
        return CODE_W'(a - b);
    endfunction

    // Wrap-around addition, used by the offset accumulator and the backward stage.
    function automatic code_t code_add(input code_t a, input code_t b);
        return CODE_W'(a + b);
    endfunction

endpackage

// File: rtl/rotor_table_rf.sv
// Rotor wiring storage: 64x6 register file, one synchronous write, one combinational read.
// Contents are intentionally not reset; the table is always reloaded before use.
module rotor_table_rf
    import enigma_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CODE_W-1:0] rd_data_c
);

    logic [CODE_W-1:0] mem_q [TABLE_DEPTH];

    // Write port: one entry per cycle while loading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: combinational lookup feeding the output register in the parent.
    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/rotor_a_forward.sv
// Rotor A forward stage: loads a 64-entry wiring table, then maps each accepted
// character through the table at an offset that advances by STEP per character.
module rotor_a_forward
    import enigma_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              table_load,
    input  logic [CODE_W-1:0] table_data,
    input  logic              crypt_mode,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              crypt_mode_buf,
    output logic [CODE_W-1:0] shift_accu,
    output logic [CODE_W-1:0] shift_accu_pipe
);

    localparam logic [CODE_W-1:0] STEP_C   = CODE_W'(STEP);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TABLE_DEPTH - 1);

    logic [ST_W-1:0]   state_q,          state_d;
    logic [ADDR_W-1:0] load_cnt_q,       load_cnt_d;
    logic              in_ready_q,       in_ready_d;
    logic              out_valid_q,      out_valid_d;
    logic [CODE_W-1:0] out_code_q,       out_code_d;
    logic              crypt_mode_buf_q, crypt_mode_buf_d;
    logic [CODE_W-1:0] shift_accu_q,     shift_accu_d;
    logic [CODE_W-1:0] shift_pipe_q,     shift_pipe_d;

    logic              accept_c;
    logic              load_last_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [CODE_W-1:0] rd_data_c;

    // Handshake and load bookkeeping; a load request always beats a character.
    always_comb begin
        accept_c    = in_valid & in_ready_q & ~table_load;
        load_last_c = table_load & (state_q == ST_LOAD) & (load_cnt_q == LAST_IDX);
        wr_addr_c   = (state_q == ST_LOAD) ? load_cnt_q : '0;
        rd_addr_c   = ADDR_W'(code_sub(in_code, shift_accu_q));
    end

    rotor_table_rf u_table (
        .clk       (clk),
        .wr_en     (table_load),
        .wr_addr   (wr_addr_c),
        .wr_data   (table_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Next-state logic: any load pulse outside LOAD writes entry 0 and restarts loading.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        in_ready_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (table_load) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = ADDR_W'(1);
                end
            end
            ST_LOAD: begin
                if (table_load) begin
                    if (load_last_c) begin
                        state_d    = ST_RUN;
                        load_cnt_d = '0;
                    end else begin
                        load_cnt_d = ADDR_W'(load_cnt_q + ADDR_W'(1));
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                load_cnt_d = '0;
            end
        endcase
        in_ready_d = (state_d == ST_RUN);
    end

    // Datapath next values: output register, offset accumulator and mode latch.
    always_comb begin
        out_valid_d      = accept_c;
        out_code_d       = out_code_q;
        shift_pipe_d     = shift_pipe_q;
        shift_accu_d     = shift_accu_q;
        crypt_mode_buf_d = crypt_mode_buf_q;
        if (accept_c) begin
            out_code_d   = rd_data_c;
            shift_pipe_d = shift_accu_q;
            shift_accu_d = code_add(shift_accu_q, STEP_C);
        end
        if (load_last_c) begin
            shift_accu_d     = '0;
            crypt_mode_buf_d = crypt_mode;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            load_cnt_q       <= '0;
            in_ready_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_code_q       <= '0;
            crypt_mode_buf_q <= 1'b0;
            shift_accu_q     <= '0;
            shift_pipe_q     <= '0;
        end else begin
            state_q          <= state_d;
            load_cnt_q       <= load_cnt_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            out_code_q       <= out_code_d;
            crypt_mode_buf_q <= crypt_mode_buf_d;
            shift_accu_q     <= shift_accu_d;
            shift_pipe_q     <= shift_pipe_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_code        = out_code_q;
    assign crypt_mode_buf  = crypt_mode_buf_q;
    assign shift_accu      = shift_accu_q;
    assign shift_accu_pipe = shift_pipe_q;

endmodule

// File: tb/tb_rotor_a_forward.sv
// Scoreboard bench for rotor_a_forward, including a model of the backward stage.
module tb_rotor_a_forward;
    import enigma_pkg::*;

    localparam int unsigned TB_STEP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       table_load = 1'b0;
    logic [5:0] table_data = '0;
    logic       crypt_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_code = '0;
    logic       in_ready, out_valid, crypt_mode_buf;
    logic [5:0] out_code, shift_accu, shift_accu_pipe;

    rotor_a_forward #(.STEP(TB_STEP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .table_load      (table_load),
        .table_data      (table_data),
        .crypt_mode      (crypt_mode),
        .in_valid        (in_valid),
        .in_code         (in_code),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_code        (out_code),
        .crypt_mode_buf  (crypt_mode_buf),
        .shift_accu      (shift_accu),
        .shift_accu_pipe (shift_accu_pipe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] out;
        logic [5:0] shift;
        logic [5:0] in;
        logic       chain;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    logic [5:0] tbl_m [64];
    logic [5:0] inv_m [64];
    logic       perm_m = 1'b0;
    logic [5:0] shift_m = '0;
    logic [5:0] last_out = '0;
    logic [5:0] t [64];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard and re-runs the result through the backward model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_code", 32'(out_code), 32'(e.out));
                chk("shift_pipe", 32'(shift_accu_pipe), 32'(e.shift));
                if (e.chain)
                    chk("backward_chain", 32'(6'(inv_m[out_code] + shift_accu_pipe)), 32'(e.in));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        sb.delete();
        shift_m = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_shift_accu", 32'(shift_accu), 32'd0);
        chk("rst_shift_pipe", 32'(shift_accu_pipe), 32'd0);
        chk("rst_mode_buf", 32'(crypt_mode_buf), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic load_table(input logic [5:0] tt [64], input logic perm, input int stall_at,
                              input logic mode, input logic with_char);
        for (int i = 0; i < 64; i++) begin
            if (i == stall_at) begin
                table_load = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cyc();
                    chk("stall_ready", 32'(in_ready), 32'd0);
                end
            end
            table_load = 1'b1;
            table_data = tt[i];
            crypt_mode = (i == 63) ? mode : ~mode;
            if (i == 0 && with_char) begin
                in_valid = 1'b1;
                in_code  = 6'($urandom);
            end
            cyc();
            in_valid = 1'b0;
            if (i == 0 && with_char)
                chk("drop_out_valid", 32'(out_valid), 32'd0);
            if (i < 63) begin
                chk("load_ready", 32'(in_ready), 32'd0);
                if (i == 0 || i == 31)
                    chk("load_shift_hold", 32'(shift_accu), 32'(shift_m));
            end
        end
        table_load = 1'b0;
        chk("run_ready", 32'(in_ready), 32'd1);
        chk("reload_shift", 32'(shift_accu), 32'd0);
        chk("mode_buf", 32'(crypt_mode_buf), 32'(mode));
        shift_m = '0;
        perm_m  = perm;
        for (int i = 0; i < 64; i++) begin
            tbl_m[i]        = tt[i];
            inv_m[tt[i]]    = 6'(i);
        end
    endtask

    task automatic send(input logic [5:0] code);
        exp_t e;
        e.in    = code;
        e.shift = shift_m;
        e.out   = tbl_m[6'(code - shift_m)];
        e.chain = perm_m;
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_code  = code;
        sb.push_back(e);
        last_out = e.out;
        shift_m  = 6'(shift_m + 6'(TB_STEP));
        cyc();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            cyc();
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic shuffle_table();
        for (int i = 0; i < 64; i++) t[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            int j;
            logic [5:0] tmp;
            j    = int'($urandom_range(i, 0));
            tmp  = t[i];
            t[i] = t[j];
            t[j] = tmp;
        end
    endtask

    initial begin
        int v0;
        reset_dut();

        // Characters while idle are ignored.
        in_valid = 1'b1;
        in_code  = 6'd9;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_shift", 32'(shift_accu), 32'd0);
        end
        in_valid = 1'b0;

        // Identity table, single character.
        for (int i = 0; i < 64; i++) t[i] = 6'(i);
        load_table(t, 1'b1, -1, 1'b1, 1'b0);
        send(6'd5);
        chk("id_out_code", 32'(out_code), 32'd5);
        chk("id_out_valid", 32'(out_valid), 32'd1);
        chk("id_shift", 32'(shift_accu), 32'd1);
        chk("id_shift_pipe", 32'(shift_accu_pipe), 32'd0);
        drain();
        cyc();
        chk("hold_out_code", 32'(out_code), 32'(last_out));
        chk("hold_out_valid", 32'(out_valid), 32'd0);

        // Offset-7 table with a load stall at entry 30, then a 64-character burst of code 0.
        for (int i = 0; i < 64; i++) t[i] = 6'(i + 7);
        load_table(t, 1'b1, 30, 1'b0, 1'b0);
        v0 = n_valid;
        for (int i = 0; i < 64; i++) begin
            send(6'd0);
            chk("burst_valid", 32'(out_valid), 32'd1);
            if (i == 62) chk("shift_63", 32'(shift_accu), 32'd63);
        end
        chk("wrap_shift", 32'(shift_accu), 32'd0);
        drain();
        chk("burst_count", 32'(n_valid - v0), 32'd64);

        // Reload from RUN with a simultaneous character; random permutation, all 64 codes.
        send(6'd3);
        send(6'd4);
        drain();
        shuffle_table();
        load_table(t, 1'b1, -1, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) send(6'(i * 5 + 1));
        drain();

        // Duplicate entries map as written.
        for (int i = 0; i < 64; i++) t[i] = 6'(i / 2);
        load_table(t, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send(6'($urandom));
        drain();

        // Reset in the middle of a stream.
        shuffle_table();
        load_table(t, 1'b1, -1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(6'($urandom));
        in_valid = 1'b1;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_code  = 6'($urandom);
            cyc();
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
            chk("post_rst_ready", 32'(in_ready), 32'd0);
            chk("post_rst_shift", 32'(shift_accu), 32'd0);
        end
        in_valid = 1'b0;
        load_table(t, 1'b1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(6'($urandom));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rotor_a_forward.md
ROTOR_A_FORWARD -- requirements
Module: rotor_a_forward

Interface
REQ-001 Parameter STEP, default 1, shift_accu increment per accepted character (mod 64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 table_load  input  1  high = table_data holds the next rotor A entry.
REQ-005 table_data  input  6  rotor A wiring entry, written in index order 0..63.
REQ-006 crypt_mode  input  1  mode select, sampled into crypt_mode_buf at the end of load.
REQ-007 in_valid  input  1  character present on in_code.
REQ-008 in_code  input  6  plaintext/ciphertext code, 0..63.
REQ-009 in_ready  output  1  high only in RUN; character accepted when in_valid & in_ready.
REQ-010 out_valid  output  1  out_code valid this cycle.
REQ-011 out_code  output  6  forward-mapped code.
REQ-012 crypt_mode_buf  output  1  latched mode for the downstream backward stage.
REQ-013 shift_accu  output  6  current rotor offset.
REQ-014 shift_accu_pipe  output  6  offset used for the character now on out_code.

Function
REQ-015 FSM states: IDLE, LOAD, RUN; IDLE after reset.
REQ-016 table_load high in any state writes table_data to entry 0 if not in LOAD, else to entry load_cnt; the FSM enters or stays in LOAD.
REQ-017 load_cnt counts 0..63; the write to entry 63 moves the FSM to RUN next cycle, clears shift_accu to 0, latches crypt_mode into crypt_mode_buf.
REQ-018 table_load low during LOAD stalls load_cnt; no write, no state change.
REQ-019 Mapping per accepted character: out_code = table[(in_code - shift_accu) mod 64], 6-bit wrap-around subtraction, no saturation; exact inverse of the backward stage given the same shift.
REQ-020 Latency exactly 1 cycle: out_valid and out_code registered on the cycle after acceptance; out_valid low otherwise; out_code holds its last value when out_valid is low.
REQ-021 On acceptance, shift_accu_pipe <= shift_accu and shift_accu <= shift_accu + STEP (mod 64, 63+1 wraps to 0).
REQ-022 Full throughput: one character per cycle in RUN, no bubbles.
REQ-023 in_valid outside RUN is ignored; no output, shift_accu unchanged.
REQ-024 table_load and in_valid both high in RUN: load wins, character dropped, out_valid low next cycle, shift_accu unchanged until load completes.
REQ-025 Table contents are not checked for being a permutation; duplicate entries map as written.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, load_cnt 0, in_ready 0, out_valid 0, out_code 0, shift_accu 0, shift_accu_pipe 0, crypt_mode_buf 0.
REQ-027 Table storage is not reset; it must be reloaded after reset.
REQ-028 Reset mid-LOAD or mid-RUN abandons the operation; no out_valid pulse after rst_n deasserts until a full load completes.

Structure
REQ-029 Shared package enigma_pkg holds CODE_W=6, TABLE_DEPTH=64, and the rotor FSM state enum.
REQ-030 Table storage is a sub-module rotor_table_rf: 64x6 register file, one synchronous write port, one combinational read port.
REQ-031 Index subtraction, shift accumulator, and output registers live in rotor_a_forward.

Verification
REQ-032 Load identity table (entry i = i), send in_code 5 -> out_code 5 after 1 cycle, shift_accu 1, shift_accu_pipe 0.
REQ-033 Load table entry i = (i+7) mod 64, send 64 consecutive in_code 0 -> out_code 7, 6, 5, ..., 8; shift_accu wraps 63->0; continuous out_valid.
REQ-034 Deassert table_load for 3 cycles at load_cnt 30 -> still exactly 64 writes; RUN entered after entry 63; in_ready low throughout LOAD.
REQ-035 In RUN assert table_load and in_valid together -> no out_valid next cycle; new load starts at entry 0; shift_accu 0 after reload.
REQ-036 Assert rst_n low mid-stream -> all outputs 0 immediately (async); in_valid ignored until reload completes.
REQ-037 Chain with the backward stage using the same table and shift_accu_pipe -> backward output equals original in_code for all 64 codes.
